// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared helpers for the register file: address-width
//                function and vector typedefs.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    // Largest data width the typedef helpers below are sized for.
    localparam int RF_MAX_DW = 64;
    // Largest address width the typedef helpers below are sized for.
    localparam int RF_MAX_AW = 16;

    // Full-width helper types.
    // Narrower instances use the low bits of these types.
    typedef logic [RF_MAX_DW-1:0] rf_word_t;
    typedef logic [RF_MAX_AW-1:0] rf_addr_t;

    // Address width for a given entry count.
    // The result is never less than 1, so that a degenerate count still
    // produces a legal vector.
    function automatic int addr_w(input int n_entries);
        int w;
        w = $clog2(n_entries);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wr_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wr_sel
//  Description : Priority select across write ports for one address.
//                The module reports whether any enabled write port targets
//                i_addr. It also returns that port's data. The
//                highest-index matching port wins.
//  Ports       : i_addr   - address being examined
//                i_dst    - write address per write port
//                i_data   - write data per write port
//                i_wr_en  - write enable per write port
//                o_hit    - some enabled port targets i_addr
//                o_data   - data of the winning port (0 when no hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_sel
    import rf_pkg::*;
#(
    parameter int WRITE_PORTS = 1,
    parameter int AW          = 2,
    parameter int DW          = 8
) (
    input  logic [AW-1:0] i_addr,
    input  logic [AW-1:0] i_dst   [WRITE_PORTS],
    input  logic [DW-1:0] i_data  [WRITE_PORTS],
    input  logic          i_wr_en [WRITE_PORTS],
    output logic          o_hit,
    output logic [DW-1:0] o_data
);

    // The loop scans ports in ascending index order.
    // A later match overwrites an earlier one, so the highest-index port
    // wins a conflict.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (i_wr_en[w] && (i_dst[w] == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_data[w];
            end
        end
    end

endmodule : rf_wr_sel
`default_nettype wire

// File: rtl/rf.sv
`default_nettype none
// ============================================================================
//  Module      : rf
//  Description : Parameterised multi-port register file.
//                Reads are combinational, with optional write-through
//                forwarding. Writes are synchronous. Reset is synchronous
//                and clears every entry.
//  Ports       : clock    - single clock, posedge active
//                reset    - synchronous active-high clear of all entries
//                src      - read address per read port
//                dst      - write address per write port
//                datain   - write data per write port
//                wr_en    - write enable per write port
//                dataout  - read data per read port
//  Revision    : 1.0 - initial release
// ============================================================================
module rf
    import rf_pkg::*;
#(
    parameter  int entries       = 4,
    parameter  int data_bus_size = 8,
    parameter  int read_ports    = 2,
    parameter  int write_ports   = 1,
    parameter  int bypass        = 1,
    localparam int AW            = addr_w(entries),
    localparam int DW            = data_bus_size
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] src     [read_ports],
    input  logic [AW-1:0] dst     [write_ports],
    input  logic [DW-1:0] datain  [write_ports],
    input  logic          wr_en   [write_ports],
    output logic [DW-1:0] dataout [read_ports]
);

    // One extra bit lets the entry count itself be represented.
    // This matters when entries is a power of two.
    localparam logic [AW:0] c_entries = (AW+1)'(entries);

    logic [DW-1:0] r_mem_q     [entries];
    logic [DW-1:0] w_mem_d     [entries];
    logic          w_ent_hit   [entries];
    logic [DW-1:0] w_ent_data  [entries];

    logic          w_byp_hit   [read_ports];
    logic [DW-1:0] w_byp_data  [read_ports];
    logic          w_src_ok    [read_ports];

    // ------------------------------------------------------------------
    // Storage: each entry compares against its own fixed index.
    // A dst at or beyond the entry count matches no entry, so the write
    // is dropped.
    // ------------------------------------------------------------------
    for (genvar e = 0; e < entries; e++) begin : g_entry
        localparam logic [AW-1:0] c_idx = AW'(e);

        rf_wr_sel #(
            .WRITE_PORTS (write_ports),
            .AW          (AW),
            .DW          (DW)
        ) u_wr_sel (
            .i_addr  (c_idx),
            .i_dst   (dst),
            .i_data  (datain),
            .i_wr_en (wr_en),
            .o_hit   (w_ent_hit[e]),
            .o_data  (w_ent_data[e])
        );
    end : g_entry

    always_comb begin
        for (int e = 0; e < entries; e++) begin
            w_mem_d[e] = w_ent_hit[e] ? w_ent_data[e] : r_mem_q[e];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < entries; e++) begin
                r_mem_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < entries; e++) begin
                r_mem_q[e] <= w_mem_d[e];
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: each read port reuses the same priority select.
    // It is applied against that port's read address.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < read_ports; r++) begin : g_rd
        if (bypass != 0) begin : g_byp
            rf_wr_sel #(
                .WRITE_PORTS (write_ports),
                .AW          (AW),
                .DW          (DW)
            ) u_byp_sel (
                .i_addr  (src[r]),
                .i_dst   (dst),
                .i_data  (datain),
                .i_wr_en (wr_en),
                .o_hit   (w_byp_hit[r]),
                .o_data  (w_byp_data[r])
            );
        end : g_byp
        else begin : g_no_byp
            assign w_byp_hit[r]  = 1'b0;
            assign w_byp_data[r] = '0;
        end : g_no_byp
    end : g_rd

    // Read mux.
    // An out-of-range address reads 0 and never forwards, because that
    // write is dropped anyway. Forwarding is masked during reset, so
    // reads then show the stored contents.
    always_comb begin
        for (int r = 0; r < read_ports; r++) begin
            w_src_ok[r] = ({1'b0, src[r]} < c_entries);
            dataout[r]  = '0;
            if (w_src_ok[r]) begin
                if (!reset && w_byp_hit[r]) begin
                    dataout[r] = w_byp_data[r];
                end else begin
                    dataout[r] = r_mem_q[src[r]];
                end
            end
        end
    end

endmodule : rf
`default_nettype wire

// File: tb/tb_rf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf
//  Description : Self-checking bench for rf. It drives two configurations:
//                  A: 4 entries, 8 bit, 2R/1W, forwarding on
//                  B: 3 entries, 8 bit, 2R/2W, forwarding off
//                Expected read values are queued with the cycle in which
//                they must appear. A monitor pops and compares them on the
//                falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;

    logic [1:0] a_src  [2];
    logic [1:0] a_dst  [1];
    logic [7:0] a_din  [1];
    logic       a_we   [1];
    logic [7:0] a_dout [2];

    logic [1:0] b_src  [2];
    logic [1:0] b_dst  [2];
    logic [7:0] b_din  [2];
    logic       b_we   [2];
    logic [7:0] b_dout [2];

    rf #(
        .entries       (4),
        .data_bus_size (8),
        .read_ports    (2),
        .write_ports   (1),
        .bypass        (1)
    ) u_a (
        .clock   (clock),
        .reset   (reset),
        .src     (a_src),
        .dst     (a_dst),
        .datain  (a_din),
        .wr_en   (a_we),
        .dataout (a_dout)
    );

    rf #(
        .entries       (3),
        .data_bus_size (8),
        .read_ports    (2),
        .write_ports   (2),
        .bypass        (0)
    ) u_b (
        .clock   (clock),
        .reset   (reset),
        .src     (b_src),
        .dst     (b_dst),
        .datain  (b_din),
        .wr_en   (b_we),
        .dataout (b_dout)
    );

    typedef struct {
        int         cyc;
        int         dut;
        int         port;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clock) begin
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = (e.dut == 0) ? a_dout[e.port] : b_dout[e.port];
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         e.name, act, e.exp, cyc, e.cyc);
            end
        end
    end

    task automatic expect_out(input int dut, input int port,
                              input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.dut  = dut;
        e.port = port;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic a_drive(input logic we, input logic [1:0] d, input logic [7:0] v,
                           input logic [1:0] s0, input logic [1:0] s1);
        a_we[0]  = we;
        a_dst[0] = d;
        a_din[0] = v;
        a_src[0] = s0;
        a_src[1] = s1;
    endtask

    task automatic b_drive(input logic we0, input logic [1:0] d0, input logic [7:0] v0,
                           input logic we1, input logic [1:0] d1, input logic [7:0] v1,
                           input logic [1:0] s0, input logic [1:0] s1);
        b_we[0]  = we0;
        b_dst[0] = d0;
        b_din[0] = v0;
        b_we[1]  = we1;
        b_dst[1] = d1;
        b_din[1] = v1;
        b_src[0] = s0;
        b_src[1] = s1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_drive(1'b0, 2'd0, 8'd0, 2'd1, 2'd3);
        b_drive(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, 2'd0, 2'd1);
        step();
        expect_out(0, 0, 8'h00, "a_reset_p0");
        expect_out(0, 1, 8'h00, "a_reset_p1");
        expect_out(1, 0, 8'h00, "b_reset_p0");
        expect_out(1, 1, 8'h00, "b_reset_p1");
        step();

        // Same-cycle forwarding, then the stored value.
        reset = 1'b0;
        a_drive(1'b1, 2'd3, 8'd47, 2'd0, 2'd3);
        expect_out(0, 1, 8'd47, "a_bypass_47");
        expect_out(0, 0, 8'h00, "a_bypass_other_port");
        step();
        a_drive(1'b0, 2'd3, 8'd47, 2'd0, 2'd3);
        expect_out(0, 1, 8'd47, "a_stored_47");
        expect_out(0, 0, 8'h00, "a_stored_entry0");
        step();

        // Back-to-back writes to entry 1.
        a_drive(1'b1, 2'd1, 8'hFF, 2'd1, 2'd3);
        expect_out(0, 0, 8'hFF, "a_b2b_ff");
        expect_out(0, 1, 8'd47, "a_b2b_e3");
        step();
        a_drive(1'b0, 2'd1, 8'h00, 2'd1, 2'd3);
        expect_out(0, 0, 8'hFF, "a_b2b_ff_stored");
        step();
        a_drive(1'b1, 2'd1, 8'h00, 2'd1, 2'd3);
        expect_out(0, 0, 8'h00, "a_b2b_00");
        step();
        a_drive(1'b0, 2'd1, 8'h00, 2'd1, 2'd3);
        expect_out(0, 0, 8'h00, "a_b2b_00_stored");
        step();

        // Reset beats a write; forwarding is masked while reset is high.
        reset = 1'b1;
        a_drive(1'b1, 2'd2, 8'd5, 2'd2, 2'd3);
        expect_out(0, 0, 8'h00, "a_rst_no_bypass");
        expect_out(0, 1, 8'd47, "a_rst_stored_e3");
        step();
        reset = 1'b0;
        a_drive(1'b0, 2'd2, 8'd5, 2'd2, 2'd3);
        expect_out(0, 0, 8'h00, "a_rst_wins_e2");
        expect_out(0, 1, 8'h00, "a_rst_cleared_e3");
        step();

        // Exhaustive fill and readback.
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b1, 2'(i), 8'(i * 17), 2'd0, 2'd0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b0, 2'd0, 8'd0, 2'(i), 2'(3 - i));
            expect_out(0, 0, 8'(i * 17), "a_exh_p0");
            expect_out(0, 1, 8'((3 - i) * 17), "a_exh_p1");
            step();
        end

        // B: two ports write the same entry, port 1 wins. There is no
        // forwarding, so the stored value is read before the edge.
        b_drive(1'b1, 2'd0, 8'd10, 1'b1, 2'd0, 8'd20, 2'd0, 2'd1);
        expect_out(1, 0, 8'h00, "b_no_bypass");
        step();
        b_drive(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, 2'd0, 2'd1);
        expect_out(1, 0, 8'd20, "b_conflict_hi_wins");
        step();

        // Out-of-range write is dropped; out-of-range read gives 0.
        b_drive(1'b1, 2'd1, 8'd33, 1'b1, 2'd3, 8'd99, 2'd1, 2'd3);
        expect_out(1, 0, 8'h00, "b_pre_edge_e1");
        expect_out(1, 1, 8'h00, "b_oor_read_with_write");
        step();
        b_drive(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, 2'd1, 2'd3);
        expect_out(1, 0, 8'd33, "b_e1_stored");
        expect_out(1, 1, 8'h00, "b_oor_read");
        step();
        b_drive(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, 2'd2, 2'd0);
        expect_out(1, 0, 8'h00, "b_e2_no_alias");
        expect_out(1, 1, 8'd20, "b_e0_kept");
        step();

        // Distinct targets on both ports in one cycle.
        b_drive(1'b1, 2'd2, 8'd7, 1'b1, 2'd1, 8'd8, 2'd2, 2'd1);
        step();
        b_drive(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, 2'd2, 2'd1);
        expect_out(1, 0, 8'd7, "b_dual_e2");
        expect_out(1, 1, 8'd8, "b_dual_e1");
        step();

        step();
        step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rf
`default_nettype wire
